// File: rtl/win5x5_line_buffer_if.sv
// Pixel-stream in / 5x5 window out bundle for win5x5_line_buffer.
// win_last exists only when WIN_LAST_EN is defined.
interface win5x5_line_buffer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]    pix_in;
    logic                pix_valid;
    logic                sof;
    logic [25*WIDTH-1:0] win_out;
    logic                win_valid;
`ifdef WIN_LAST_EN
    logic                win_last;

    modport master (output pix_in, output pix_valid, output sof,
                    input win_out, input win_valid, input win_last);
    modport slave  (input pix_in, input pix_valid, input sof,
                    output win_out, output win_valid, output win_last);
`else
    modport master (output pix_in, output pix_valid, output sof,
                    input win_out, input win_valid);
    modport slave  (input pix_in, input pix_valid, input sof,
                    output win_out, output win_valid);
`endif
endinterface

// File: rtl/win5x5_line_buffer.sv
// Raster-stream to 5x5 window generator: four line buffers feed a 5x5 register window.
// Optional WIN_LAST_EN adds win_last, flagging the final window of a frame.
module win5x5_line_buffer #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input logic clk,
    input logic rst,
    win5x5_line_buffer_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(4);
    localparam logic [RW-1:0] ROW_MIN  = RW'(4);

    logic [CW-1:0]       col, cur_col;
    logic [RW-1:0]       row, cur_row;
    logic                accept, emit, last_pix;
    logic [WIDTH-1:0]    lb [4][IMG_W];
    logic [WIDTH-1:0]    win [5][5];
    logic [WIDTH-1:0]    win_nxt [5][5];
    logic [WIDTH-1:0]    new_col [5];
    logic [25*WIDTH-1:0] win_flat;

    // sof overrides the counters so the accepted pixel is always (0,0)
    always_comb begin
        accept   = bus.pix_valid;
        cur_col  = bus.sof ? '0 : col;
        cur_row  = bus.sof ? '0 : row;
        emit     = accept && !bus.sof && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
        last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

        new_col[0] = lb[3][cur_col];
        new_col[1] = lb[2][cur_col];
        new_col[2] = lb[1][cur_col];
        new_col[3] = lb[0][cur_col];
        new_col[4] = bus.pix_in;

        win_flat = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][4] = new_col[r];
            for (int c = 0; c < 5; c++) begin
                win_flat[(r*5+c)*WIDTH +: WIDTH] = win_nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Storage is left uncleared; row/col gating keeps stale contents from ever being emitted
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            win            <= win_nxt;
            lb[0][cur_col] <= bus.pix_in;
            lb[1][cur_col] <= lb[0][cur_col];
            lb[2][cur_col] <= lb[1][cur_col];
            lb[3][cur_col] <= lb[2][cur_col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.win_valid <= 1'b0;
            bus.win_out   <= '0;
        end else begin
            bus.win_valid <= emit;
            if (emit) begin
                bus.win_out <= win_flat;
            end
        end
    end

`ifdef WIN_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.win_last <= 1'b0;
        end else begin
            bus.win_last <= emit && last_pix;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_pix;
`endif
endmodule

// File: tb/tb_win5x5_line_buffer.sv
// Scoreboard bench for win5x5_line_buffer on an 8x6 image; define WIN_LAST_EN to also check win_last.
module tb_win5x5_line_buffer;
    localparam int WIDTH = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WW    = 25 * WIDTH;

    typedef struct {
        logic [WW-1:0] win;
        bit            last;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    win5x5_line_buffer_if #(.WIDTH(WIDTH)) bus ();

    win5x5_line_buffer #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Window completed at (r,c) of an image whose pixel value is r*IMG_W+c
    function automatic logic [WW-1:0] exp_win(input int r, input int c);
        logic [WW-1:0] w;
        int v;
        w = '0;
        for (int k = 0; k < 25; k++) begin
            v = (r - 4 + k / 5) * IMG_W + (c - 4 + k % 5);
            w[k*WIDTH +: WIDTH] = WIDTH'(v);
        end
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int r, input int c, input bit s, input int gap);
        bus.pix_in    = WIDTH'(r * IMG_W + c);
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        if (r >= 4 && c >= 4) begin
            sb.push_back('{win: exp_win(r, c), last: (r == IMG_H-1 && c == IMG_W-1), cyc: cyc + 1});
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit first_sof, input int max_gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            apply_stimulus(i / IMG_W, i % IMG_W, first_sof && (i == 0),
                           (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic drain(input string tag);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_output(tag, WW'(sb.size()), WW'(0));
        sb.delete();
    endtask

    task automatic apply_reset(input bit with_pix, input int cycles);
        rst           = 1'b1;
        bus.pix_valid = with_pix;
        bus.pix_in    = 8'hAA;
        bus.sof       = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.pix_valid = 1'b0;
        check_output("reset_valid", WW'(bus.win_valid), WW'(0));
        check_output("reset_win", bus.win_out, WW'(0));
`ifdef WIN_LAST_EN
        check_output("reset_last", WW'(bus.win_last), WW'(0));
`endif
    endtask

    initial begin
        rst           = 1'b1;
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (bus.win_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        check_output("spurious_window", WW'(bus.win_valid), WW'(0));
                    end else begin
                        e = sb.pop_front();
                        check_output("window", bus.win_out, e.win);
                        check_output("latency", WW'(cyc), WW'(e.cyc));
`ifdef WIN_LAST_EN
                        check_output("win_last", WW'(bus.win_last), WW'(e.last));
`endif
                    end
                end
`ifdef WIN_LAST_EN
                else if (bus.win_last !== 1'bx) begin
                    check_output("last_idle", WW'(bus.win_last), WW'(0));
                end
`endif
            end
        join_none

        $display("[TB] reset");
        apply_reset(1'b0, 2);

        $display("[TB] continuous frame");
        send_frame(1'b1, 0, IMG_W * IMG_H);
        drain("frame_cont_missing");

        $display("[TB] frame with gaps");
        send_frame(1'b1, 3, IMG_W * IMG_H);
        drain("frame_gaps_missing");

        $display("[TB] back-to-back frames");
        send_frame(1'b1, 0, IMG_W * IMG_H);
        send_frame(1'b0, 0, IMG_W * IMG_H);
        drain("two_frames_missing");

        $display("[TB] sof restart at index 20");
        send_frame(1'b1, 0, 20);
        send_frame(1'b1, 0, IMG_W * IMG_H);
        drain("sof_restart_missing");

        $display("[TB] reset mid-frame at index 40");
        send_frame(1'b1, 0, 40);
        apply_reset(1'b1, 1);
        send_frame(1'b0, 0, IMG_W * IMG_H);
        drain("reset_mid_missing");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/win5x5_line_buffer.md
# win5x5_line_buffer

Streaming 5×5 window generator that converts a raster-order pixel stream into the packed 25-pixel bus consumed by the downstream max-pool, min-pool and blur stages. It keeps four previous image lines in line buffers and a 5×5 register window. Each time an accepted pixel completes a full in-bounds 5×5 neighbourhood, it emits that neighbourhood with a one-cycle valid strobe. It sits between the pixel source (camera/feature-map reader) and the 25-pixel reduction stages.

## Interface
- WIDTH, 8, bits per pixel
- IMG_W, 28, pixels per line (≥5)
- IMG_H, 28, lines per frame (≥5)
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pix_in  input  WIDTH  incoming pixel, raster order (left→right, top→bottom)
- pix_valid  input  1  pix_in accepted on this cycle; no backpressure, source may gap freely
- sof  input  1  qualifies pix_valid; marks the accepted pixel as (row 0, col 0) of a new frame
- win_out  output  25*WIDTH  window; element k = row k/5, col k%5, bits [WIDTH*(k+1)-1 : WIDTH*k]; row 0 = oldest line, col 0 = leftmost
- win_valid  output  1  single-cycle strobe, win_out holds a new window
- win_last  output  1  present only with WIN_LAST_EN; see Configuration

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next pixel. They advance only on pix_valid. col wraps to 0 and row increments. After (IMG_H-1, IMG_W-1) both wrap to 0.
- pix_valid & sof: the pixel is treated as (0,0) regardless of the counters. After it, col=1, row=0. Any partially received frame is abandoned. sof without pix_valid is ignored.
- Line buffers: 4 lines × IMG_W × WIDTH. They are written and read only on accepted pixels, indexed by col. On each accepted pixel, the column {lb3[col], lb2[col], lb1[col], lb0[col], pix_in} (oldest→newest) shifts into window column 4. Existing columns shift toward col 0. The line buffers then shift down one line at position col.
- A window is emitted when the accepted pixel is at (r,c) with r≥4 and c≥4. It covers rows r-4..r and cols c-4..c. There is no padding: (IMG_W-4)×(IMG_H-4) windows per frame.
- Stale window columns from the previous line never appear, because emission requires c≥4.
- Line-buffer contents and window registers carry no meaning across frames. Gating by row≥4 guarantees that stale data from a previous frame is never emitted.

## Timing
- Latency: win_valid asserts exactly 1 cycle after the pix_valid cycle of the completing pixel. win_out is registered alongside it.
- Throughput: one window per cycle when pix_valid is held high; gaps in pix_valid produce identical gaps in win_valid.
- win_out holds the last emitted window while win_valid is low.
- Reset values: win_valid=0, win_last=0, win_out=0, col=0, row=0. Line buffers are not cleared.
- Reset mid-frame: the next accepted pixel is (0,0). No window is emitted until 4 full lines plus 5 pixels have been accepted after reset.
- rst and pix_valid asserted together: reset wins, and the pixel is dropped.
- sof on a pixel that would otherwise complete a window: no window is emitted for that pixel.

## Configuration
- WIN_LAST_EN defined: adds output win_last. It asserts together with win_valid only for the window completed by pixel (IMG_H-1, IMG_W-1), and is 0 otherwise.
- WIN_LAST_EN undefined: the win_last port and its logic are absent; all other behaviour is identical.

## Test plan
- IMG_W=8, IMG_H=6, continuous pixels with value r*8+c and sof on the first pixel -> exactly 8 windows. The first window arrives 1 cycle after pixel index 36, with element k = (k/5)*8 + k%5 (p0=0, p12=18, p24=36). The last window has p24=47.
- Same stream with random 0-3 cycle gaps in pix_valid -> the same 8 windows in the same order, each 1 cycle after its completing pixel.
- Two back-to-back frames -> 16 windows; the second frame's windows equal the first's, with no window emitted during the second frame's rows 0-3.
- sof re-asserted at pixel index 20 of frame 1, then a full frame -> frame 1 yields no windows; the new frame yields 8 correct windows.
- rst asserted for 1 cycle at pixel index 40 -> win_valid=0 and win_out=0 next cycle. Resumed pixels are treated as starting at (0,0).
- WIN_LAST_EN defined, one frame -> win_last high only on the 8th window (p24=47).
